// File: rtl/ula_neander_acc.sv
// ---------------------------------------------------------------------------
// ula_neander_acc
//   Registered Neander ULA. It holds the accumulator (AC) and the N/Z/C flags,
//   runs one operation per accepted start pulse and answers with a one-cycle
//   done pulse.
//
//   Optional feature: define ULA_MUL_EN to build the multi-cycle shift-add
//   multiplier (op=110). Without it, op=110 acts as NOP and busy stays 0.
//
// Parameters:
//   WIDTH   datapath width of AC and b (2 or more)
//
// Ports:
//   clk     system clock, rising edge
//   rst     synchronous, active-high reset
//   start   operation request; accepted only when not busy
//   op      operation code, sampled with start
//   b       second operand, sampled with start
//   acc     accumulator (operand A and result)
//   flag_n  negative flag (acc msb)
//   flag_z  zero flag (acc == 0)
//   flag_c  carry / borrow / multiply-overflow flag
//   busy    multiply in progress
//   done    one-cycle pulse: acc and flags hold the new result
// ---------------------------------------------------------------------------
module ula_neander_acc #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] acc,
    output logic             flag_n,
    output logic             flag_z,
    output logic             flag_c,
    output logic             busy,
    output logic             done
);

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_OR  = 3'b001,
        OP_AND = 3'b010,
        OP_NOT = 3'b011,
        OP_LDA = 3'b100,
        OP_SUB = 3'b101,
        OP_MUL = 3'b110,
        OP_NOP = 3'b111
    } op_e;

    op_e cur_op;
    assign cur_op = op_e'(op);

    // -----------------------------------------------------------------------
    // Single-cycle result path
    // -----------------------------------------------------------------------
    logic [WIDTH:0]   sum_ext;
    logic [WIDTH:0]   diff_ext;
    logic [WIDTH-1:0] res;
    logic             res_c;
    logic             upd_nz;
    logic             accept_single;

    always_comb begin
        sum_ext  = {1'b0, acc} + {1'b0, b};
        // The extra msb of the extended difference is the borrow (AC < b).
        diff_ext = {1'b0, acc} - {1'b0, b};
        res      = acc;
        res_c    = flag_c;
        upd_nz   = 1'b1;
        case (cur_op)
            OP_ADD: begin
                res   = sum_ext[WIDTH-1:0];
                res_c = sum_ext[WIDTH];
            end
            OP_OR:  res = acc | b;
            OP_AND: res = acc & b;
            OP_NOT: res = ~acc;
            OP_LDA: res = b;
            OP_SUB: begin
                res   = diff_ext[WIDTH-1:0];
                res_c = diff_ext[WIDTH];
            end
            // NOP, and MUL when the multiplier is not built (or handled by
            // the multi-cycle path below): nothing changes.
            default: upd_nz = 1'b0;
        endcase
    end

`ifdef ULA_MUL_EN
    // -----------------------------------------------------------------------
    // Shift-add multiplier
    // -----------------------------------------------------------------------
    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_e;

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    state_e             state;
    logic [CW-1:0]      mul_cnt;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_next;
    logic               mul_last;

    always_comb begin
        prod_next = mplier[0] ? (prod + mcand) : prod;
        mul_last  = (mul_cnt == CW'(WIDTH - 1));
    end

    assign accept_single = (state == IDLE) && start && (cur_op != OP_MUL);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            busy    <= 1'b0;
            mul_cnt <= '0;
            mcand   <= '0;
            mplier  <= '0;
            prod    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && (cur_op == OP_MUL)) begin
                        mcand   <= {{WIDTH{1'b0}}, acc};
                        mplier  <= b;
                        prod    <= '0;
                        mul_cnt <= '0;
                        busy    <= 1'b1;
                        state   <= MUL;
                    end
                end
                MUL: begin
                    prod    <= prod_next;
                    mcand   <= mcand << 1;
                    mplier  <= mplier >> 1;
                    mul_cnt <= mul_cnt + 1'b1;
                    if (mul_last) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
`else
    assign accept_single = start;
    assign busy          = 1'b0;
`endif

    // -----------------------------------------------------------------------
    // Accumulator, flags and done
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            acc    <= '0;
            flag_n <= 1'b0;
            flag_z <= 1'b1;
            flag_c <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept_single) begin
                done   <= 1'b1;
                flag_c <= res_c;
                if (upd_nz) begin
                    acc    <= res;
                    flag_n <= res[WIDTH-1];
                    flag_z <= (res == '0);
                end
            end
`ifdef ULA_MUL_EN
            if ((state == MUL) && mul_last) begin
                done   <= 1'b1;
                acc    <= prod_next[WIDTH-1:0];
                flag_n <= prod_next[WIDTH-1];
                flag_z <= (prod_next[WIDTH-1:0] == '0);
                flag_c <= |prod_next[2*WIDTH-1:WIDTH];
            end
`endif
        end
    end

endmodule

// File: tb/tb_ula_neander_acc.sv
module tb_ula_neander_acc;

    logic       clk;
    logic       rst;
    logic       start;
    logic [2:0] op;
    logic [7:0] b;
    logic [7:0] acc;
    logic       flag_n;
    logic       flag_z;
    logic       flag_c;
    logic       busy;
    logic       done;

    int total;
    int bad;

    ula_neander_acc #(.WIDTH(8)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .b      (b),
        .acc    (acc),
        .flag_n (flag_n),
        .flag_z (flag_z),
        .flag_c (flag_c),
        .busy   (busy),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance one edge and sample 1 time unit later.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Single start pulse; returns sampled just after the accepting edge.
    task automatic do_op(input logic [2:0] o, input logic [7:0] v);
        start = 1'b1;
        op    = o;
        b     = v;
        tick();
        start = 1'b0;
    endtask

    task automatic check_state(input string tag, input logic [7:0] a,
                               input logic n, input logic z, input logic c,
                               input logic dn);
        check({tag, ".acc"},  {24'd0, acc},    {24'd0, a});
        check({tag, ".n"},    {31'd0, flag_n}, {31'd0, n});
        check({tag, ".z"},    {31'd0, flag_z}, {31'd0, z});
        check({tag, ".c"},    {31'd0, flag_c}, {31'd0, c});
        check({tag, ".done"}, {31'd0, done},   {31'd0, dn});
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        start = 1'b0;
        op    = 3'b000;
        b     = 8'h00;
        #2;
        tick();
        tick();
        check_state("reset", 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        check("reset.busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;

        // LDA, latency 1, done drops afterwards
        do_op(3'b100, 8'h05);
        check_state("lda5", 8'h05, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        check("lda5.done_low", {31'd0, done}, 32'd0);

        // ADD with carry, then OR keeps C
        do_op(3'b000, 8'hFF);
        check_state("add_ff", 8'h04, 1'b0, 1'b0, 1'b1, 1'b1);
        do_op(3'b001, 8'hF0);
        check_state("or_f0", 8'hF4, 1'b1, 1'b0, 1'b1, 1'b1);
        do_op(3'b010, 8'h3C);
        check_state("and_3c", 8'h34, 1'b0, 1'b0, 1'b1, 1'b1);

        // SUB to zero, SUB with borrow, NOT keeps C
        do_op(3'b100, 8'h04);
        check_state("lda4", 8'h04, 1'b0, 1'b0, 1'b1, 1'b1);
        do_op(3'b101, 8'h04);
        check_state("sub_eq", 8'h00, 1'b0, 1'b1, 1'b0, 1'b1);
        do_op(3'b101, 8'h01);
        check_state("sub_borrow", 8'hFF, 1'b1, 1'b0, 1'b1, 1'b1);
        do_op(3'b011, 8'hAA);
        check_state("not", 8'h00, 1'b0, 1'b1, 1'b1, 1'b1);

        // NOP: nothing changes, done still pulses
        do_op(3'b111, 8'h77);
        check_state("nop", 8'h00, 1'b0, 1'b1, 1'b1, 1'b1);

        // Back-to-back ADDs keep done high
        do_op(3'b100, 8'hFE);
        start = 1'b1;
        op    = 3'b000;
        b     = 8'h01;
        tick();
        check_state("b2b1", 8'hFF, 1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        check_state("b2b2", 8'h00, 1'b0, 1'b1, 1'b1, 1'b1);
        tick();
        check_state("b2b3", 8'h01, 1'b0, 1'b0, 1'b0, 1'b1);
        start = 1'b0;
        tick();
        check("b2b.done_low", {31'd0, done}, 32'd0);

`ifdef ULA_MUL_EN
        // 0x0C * 0x0A = 0x78; b wiggles during MUL must not matter
        do_op(3'b100, 8'h0C);
        do_op(3'b110, 8'h0A);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("mul1.busy%0d", i), {31'd0, busy}, 32'd1);
            check($sformatf("mul1.done%0d", i), {31'd0, done}, 32'd0);
            b  = 8'hFF;
            op = 3'b000;
            tick();
        end
        check_state("mul1", 8'h78, 1'b0, 1'b0, 1'b0, 1'b1);
        check("mul1.busy_end", {31'd0, busy}, 32'd0);
        tick();
        check("mul1.done_low", {31'd0, done}, 32'd0);

        // 0x20 * 0x10 = 0x200: low byte zero, overflow
        do_op(3'b100, 8'h20);
        do_op(3'b110, 8'h10);
        repeat (8) tick();
        check_state("mul2", 8'h00, 1'b0, 1'b1, 1'b1, 1'b1);

        // start during busy is ignored
        do_op(3'b100, 8'h03);
        do_op(3'b110, 8'h03);
        tick();
        do_op(3'b100, 8'h55);
        repeat (6) tick();
        check_state("mul3", 8'h09, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        check("mul3.done_low", {31'd0, done}, 32'd0);
        check("mul3.acc_hold", {24'd0, acc}, 32'h09);

        // reset in the 4th busy cycle aborts
        do_op(3'b100, 8'h03);
        do_op(3'b110, 8'h03);
        repeat (3) tick();
        check("mul4.busy_pre", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_state("mul_rst", 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        check("mul_rst.busy", {31'd0, busy}, 32'd0);
        repeat (8) tick();
        check("mul_rst.no_done", {31'd0, done}, 32'd0);
`else
        // Without the multiplier, op=110 is a NOP
        do_op(3'b100, 8'h0C);
        do_op(3'b110, 8'h0A);
        check_state("mul_nop", 8'h0C, 1'b0, 1'b0, 1'b0, 1'b1);
        check("mul_nop.busy", {31'd0, busy}, 32'd0);
        tick();
        check("mul_nop.done_low", {31'd0, done}, 32'd0);
        check("mul_nop.acc_hold", {24'd0, acc}, 32'h0C);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ula_neander_acc.md
Name: ula_neander_acc

Overview:
- Parametrised, registered successor to the combinational Neander ULA output mux.
- Holds the accumulator (AC) and the N/Z/C flags internally.
- Executes one operation per start pulse with a one-cycle done handshake; adds SUB, LDA, NOP and an optional multi-cycle shift-add multiply.
- Sits between the Neander control unit (drives start/op) and the memory data register (drives b).

Parameters:
- WIDTH, 8, datapath width of AC and b; legal range is 2 or more.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled in IDLE only
- op  input  3  operation code, sampled with start
- b  input  WIDTH  second operand, sampled with start
- acc  output  WIDTH  accumulator value (operand A and result)
- flag_n  output  1  negative flag: acc[WIDTH-1]
- flag_z  output  1  zero flag: acc == 0
- flag_c  output  1  carry/borrow/overflow flag
- busy  output  1  multi-cycle operation in progress
- done  output  1  one-cycle pulse: result and flags are valid

Behaviour:
- Reset, synchronous and active-high, one clock:
  - acc=0, flag_n=0, flag_z=1, flag_c=0, busy=0, done=0.
  - State goes to IDLE; the multiply counter clears.
  - Reset overrides start and aborts an in-progress MUL.
- Op encoding:
  - 000 ADD: AC+b
  - 001 OR: AC|b
  - 010 AND: AC&b
  - 011 NOT: ~AC (b ignored)
  - 100 LDA: b
  - 101 SUB: AC-b
  - 110 MUL: AC*b, low WIDTH bits kept
  - 111 NOP
- States: IDLE, MUL.
  - IDLE, start=1, op≠110: the result is written at that clock edge. acc, flags and done=1 are visible in the next cycle (latency 1). State stays IDLE.
  - IDLE, start=1, op=110: latch the multiplicand (AC) and multiplier (b), clear the partial product, go to MUL.
  - MUL: busy=1 for exactly WIDTH cycles. Each edge performs one shift-add iteration. The edge that completes iteration WIDTH writes acc and flags, sets done=1, clears busy and returns to IDLE. Result and done appear in cycle WIDTH+1 after the start cycle.
  - start is ignored while busy=1, with no queuing.
- done:
  - Asserted for exactly one cycle per accepted start.
  - Stays 0 otherwise.
  - start asserted in a done cycle is accepted, so back-to-back single-cycle ops keep done high continuously.
- Flags (N and Z always recomputed from the new acc, except on NOP):
  - ADD: C = carry out of bit WIDTH-1 (WIDTH+1-bit sum).
  - SUB: C = borrow, i.e. 1 when AC < b unsigned. Result wraps modulo 2^WIDTH.
  - MUL: C = 1 when the full 2*WIDTH product has any nonzero bit above WIDTH-1.
  - OR, AND, NOT, LDA: C unchanged.
  - NOP: acc and all flags unchanged; done still pulses.
- Wrap-around: all arithmetic is modulo 2^WIDTH. No saturation.
- Operands are latched at start. Changes on b or op during MUL have no effect.

Optional Feature:
- Macro: ULA_MUL_EN
- Defined: the MUL state, multiply counter and product register are compiled in, with behaviour as above.
- Undefined: no MUL hardware. op=110 behaves exactly as NOP (1-cycle done, no state change), and busy is tied to 0.

Test Plan (WIDTH=8):
1. After rst, issue LDA b=0x05. Next cycle: acc=0x05, N=0, Z=0, C=0, done=1. The following cycle: done=0.
2. From acc=0x05, ADD b=0xFF. Next cycle: acc=0x04, C=1, Z=0. Then OR b=0xF0: acc=0xF4, N=1, C still 1.
3. From acc=0x04, SUB b=0x04: acc=0x00, Z=1, C=0. Then SUB b=0x01: acc=0xFF, N=1, C=1. Then NOT: acc=0x00, Z=1, C still 1.
4. MUL, with ULA_MUL_EN defined:
   - acc=0x0C, b=0x0A: busy=1 for 8 cycles, then acc=0x78, C=0, done=1 in cycle 9.
   - acc=0x20, b=0x10: acc=0x00, Z=1, C=1.
5. Start MUL with acc=0x03, b=0x03.
   - Pulse start with op=100 during busy: it is ignored, and the result is acc=0x09.
   - Repeat the MUL and assert rst in the 4th busy cycle. Next cycle: acc=0, busy=0, done=0, Z=1.
6. From acc=0xFE, assert start every cycle with ADD b=0x01 for 3 cycles.
   - acc sequence is 0xFF, 0x00 (C=1, Z=1), 0x01 (C=0).
   - done stays high for 3 consecutive cycles.
   - Repeat with ULA_MUL_EN undefined and op=110: 1-cycle done, acc unchanged, busy=0.
